// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM addressing, instruction register with valid/ready to decode.
// Optional HALT-opcode stop is compiled in with `define FETCH_HALT_EN.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic        redirect_en,
    input  logic [15:0] redirect_addr,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted
);

    typedef enum logic [0:0] {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [15:0] PC_STRIDE  = 16'd2;
    localparam logic [15:0] ALIGN_MASK = 16'hFFFE;
`ifdef FETCH_HALT_EN
    localparam logic [3:0]  HALT_OPCODE = 4'b1111;
`endif

    state_t      state_r, state_n;
    logic [15:0] pc_r, pc_n;
    logic [15:0] instr_r, instr_n;
    logic [15:0] instr_pc_r, instr_pc_n;
    logic        instr_valid_r, instr_valid_n;
    logic        can_load_s;
`ifdef FETCH_HALT_EN
    logic        halted_r, halted_n;
`endif

    // A new word may enter the register when fetching and the slot is empty or draining.
    always_comb begin
        can_load_s = 1'b0;
        case (state_r)
            ST_FETCH:  can_load_s = !instr_valid_r || instr_ready;
            ST_HALTED: can_load_s = 1'b0;
            default:   can_load_s = 1'b0;
        endcase
    end

    // Next-state and datapath selection: redirect beats load, load beats hold.
    always_comb begin
        state_n       = state_r;
        pc_n          = pc_r;
        instr_n       = instr_r;
        instr_pc_n    = instr_pc_r;
        instr_valid_n = instr_valid_r;
`ifdef FETCH_HALT_EN
        halted_n      = halted_r;
`endif
        if (redirect_en) begin
            // The held word is discarded even if decode takes it this cycle.
            pc_n          = redirect_addr & ALIGN_MASK;
            instr_valid_n = 1'b0;
            state_n       = ST_FETCH;
`ifdef FETCH_HALT_EN
            halted_n      = 1'b0;
`endif
        end else if (can_load_s) begin
            instr_n       = rom_data;
            instr_pc_n    = pc_r;
            instr_valid_n = 1'b1;
`ifdef FETCH_HALT_EN
            if (rom_data[15:12] == HALT_OPCODE) begin
                pc_n     = pc_r;
                state_n  = ST_HALTED;
                halted_n = 1'b1;
            end else begin
                pc_n     = pc_r + PC_STRIDE;
            end
`else
            pc_n          = pc_r + PC_STRIDE;
`endif
        end else if (instr_valid_r && instr_ready) begin
            // Only reachable while halted: the last word is consumed, nothing follows.
            instr_valid_n = 1'b0;
        end else begin
            instr_valid_n = instr_valid_r;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_FETCH;
            pc_r          <= 16'h0000;
            instr_r       <= 16'h0000;
            instr_pc_r    <= 16'h0000;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_n;
            pc_r          <= pc_n;
            instr_r       <= instr_n;
            instr_pc_r    <= instr_pc_n;
            instr_valid_r <= instr_valid_n;
        end
    end

`ifdef FETCH_HALT_EN
    // Halt flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r <= 1'b0;
        end else begin
            halted_r <= halted_n;
        end
    end

    assign halted = halted_r;
`else
    assign halted = 1'b0;
`endif

    assign rom_addr    = pc_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vectors, a cycle model and literal checkpoints.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        redirect_en;
    logic [15:0] redirect_addr;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .halted        (halted)
    );

    // ROM contents: a HALT word at 0x000A, otherwise address-derived words with opcode 2.
    function automatic logic [15:0] rom_word(input logic [15:0] a);
        if (a == 16'h000A) return 16'hF000;
        return {4'h2, a[11:0] + 12'h003};
    endfunction

    assign rom_data = rom_word(rom_addr);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef FETCH_HALT_EN
    localparam bit HALT_FEATURE = 1'b1;
`else
    localparam bit HALT_FEATURE = 1'b0;
`endif

    // Reference model: the visible fetch state, advanced once per rising edge.
    bit          m_known = 1'b0;
    logic [15:0] m_pc, m_instr, m_ipc;
    logic        m_valid, m_halted;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
            m_valid = 1'b0; m_halted = 1'b0; m_known = 1'b1;
        end else if (m_known) begin
            if (redirect_en) begin
                m_pc = redirect_addr & 16'hFFFE;
                m_valid = 1'b0;
                m_halted = 1'b0;
            end else if (!m_halted && (!m_valid || instr_ready)) begin
                m_instr = rom_word(m_pc);
                m_ipc   = m_pc;
                m_valid = 1'b1;
                if (HALT_FEATURE && m_instr[15:12] == 4'hF) m_halted = 1'b1;
                else m_pc = m_pc + 16'd2;
            end else if (m_valid && instr_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare process: every falling edge once the model is anchored by reset.
    always @(negedge clk) begin
        if (m_known) begin
            chk("model rom_addr", rom_addr, m_pc);
            chk("model instr", instr, m_instr);
            chk("model instr_pc", instr_pc, m_ipc);
            chk("model instr_valid", {15'd0, instr_valid}, {15'd0, m_valid});
            chk("model halted", {15'd0, halted}, {15'd0, m_halted});
        end
    end

    task automatic cyc(input logic r, input logic re, input logic [15:0] ra, input logic rdy);
        rst = r; redirect_en = re; redirect_addr = ra; instr_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        cyc(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("reset instr_valid", {15'd0, instr_valid}, 16'h0000);
        chk("reset rom_addr", rom_addr, 16'h0000);
        chk("reset instr", instr, 16'h0000);
        chk("reset halted", {15'd0, halted}, 16'h0000);

        // Streaming from 0x0000 with decode always ready
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("first instr_pc", instr_pc, 16'h0000);
        chk("first valid", {15'd0, instr_valid}, 16'h0001);
        chk("first instr", instr, 16'h2003);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("second instr_pc", instr_pc, 16'h0002);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("third instr_pc", instr_pc, 16'h0004);
        chk("third rom_addr", rom_addr, 16'h0006);

        // Backpressure for three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 16'h0000, 1'b0);
            chk("stall instr_pc", instr_pc, 16'h0004);
            chk("stall instr", instr, 16'h2007);
            chk("stall rom_addr", rom_addr, 16'h0006);
            chk("stall valid", {15'd0, instr_valid}, 16'h0001);
        end
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("after stall instr_pc", instr_pc, 16'h0006);

        // Run into the HALT word at 0x000A
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("halt word instr", instr, 16'hF000);
        chk("halt word instr_pc", instr_pc, 16'h000A);
`ifdef FETCH_HALT_EN
        chk("halted set", {15'd0, halted}, 16'h0001);
        chk("halted rom_addr", rom_addr, 16'h000A);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("halt consumed valid", {15'd0, instr_valid}, 16'h0000);
        chk("halt rom_addr held", rom_addr, 16'h000A);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("still halted", {15'd0, halted}, 16'h0001);
        cyc(1'b0, 1'b1, 16'h0000, 1'b1);
        chk("redirect clears halted", {15'd0, halted}, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("resume instr_pc", instr_pc, 16'h0000);
        chk("resume valid", {15'd0, instr_valid}, 16'h0001);
`else
        chk("no halt rom_addr", rom_addr, 16'h000C);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("after F-word instr_pc", instr_pc, 16'h000C);
        chk("halted tied low", {15'd0, halted}, 16'h0000);
`endif

        // Redirect to an odd target while a transfer is happening
        chk("pre-redirect valid", {15'd0, instr_valid}, 16'h0001);
        cyc(1'b0, 1'b1, 16'h0047, 1'b1);
        chk("redirect valid", {15'd0, instr_valid}, 16'h0000);
        chk("redirect rom_addr", rom_addr, 16'h0046);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("target instr_pc", instr_pc, 16'h0046);
        chk("target instr", instr, 16'h2049);

        // Redirect while stalled still drops the held word
        cyc(1'b0, 1'b1, 16'h0100, 1'b0);
        chk("stalled redirect valid", {15'd0, instr_valid}, 16'h0000);
        chk("stalled redirect instr_pc kept", instr_pc, 16'h0046);

        // Wrap from 0xFFFE to 0x0000
        cyc(1'b0, 1'b1, 16'hFFFF, 1'b1);
        chk("wrap rom_addr", rom_addr, 16'hFFFE);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("wrap instr_pc top", instr_pc, 16'hFFFE);
        chk("wrap rom_addr zero", rom_addr, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("wrap instr_pc zero", instr_pc, 16'h0000);

        // Reset in the middle of a stall
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("pre-reset held valid", {15'd0, instr_valid}, 16'h0001);
        cyc(1'b1, 1'b1, 16'h1234, 1'b0);
        chk("mid-stall reset valid", {15'd0, instr_valid}, 16'h0000);
        chk("mid-stall reset instr", instr, 16'h0000);
        chk("mid-stall reset instr_pc", instr_pc, 16'h0000);
        chk("mid-stall reset rom_addr", rom_addr, 16'h0000);

        // Mixed ready pattern checked by the model
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, (i == 17) ? 1'b1 : 1'b0, 16'h0020, (i % 3 != 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
